uart_rx_os: RTL

//  Parametrised UART receiver: oversampled, majority-voted, configurable frame format (data bits, parity, stop bits).

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_baud_tick.sv | 30 +++
 rtl/uart_rx_os.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, parity selectors, divider rounding.
// Latency: n/a (constants and a constant function only).
// Backpressure: n/a.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Oversample-tick divider, rounded to nearest: round(clk_hz / (baud * ovs)).
  function automatic int uart_div(input int clk_hz, input int baud, input int ovs);
    return (clk_hz + (baud * ovs) / 2) / (baud * ovs);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: free-running 0..DIV-1 counter, one-clk os_tick at DIV-1.
// Latency: first tick DIV clks after reset release, then every DIV clks.
// Backpressure: none; free-running.
// Ports: clk, n_rst (async active-low), os_tick (out, 1-clk pulse).
module uart_baud_tick #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic n_rst,
  output logic os_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign os_tick = (r_cnt == CNT_LAST);

endmodule

// File: rtl/uart_rx_os.sv
// Oversampled UART receiver with 2-of-3 mid-bit vote, configurable data/parity/stop format.
// Latency: rx_valid rises 1 clk after the vote tick of the last stop bit.
// Backpressure: one-deep holding register; a frame arriving while it is full is dropped and sets sticky overrun.
// Ports: clk, n_rst (async active-low), rxd (async serial in), rx_data/rx_valid/rx_ready handshake,
//        frame_err, parity_err (qualify the held frame), overrun (sticky until handshake), busy (FSM not idle).
module uart_rx_os #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BAUD      = 115200,
  parameter int OVS       = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);
  import uart_pkg::*;

  localparam int DIV = uart_div(CLK_HZ, BAUD, OVS);
  localparam int OW  = $clog2(OVS);
  localparam logic [OW-1:0] OS_S0  = OW'(OVS / 2 - 1);
  localparam logic [OW-1:0] OS_S1  = OW'(OVS / 2);
  localparam logic [OW-1:0] OS_S2  = OW'(OVS / 2 + 1);
  localparam logic [OW-1:0] OS_END = OW'(OVS - 1);
  localparam logic [3:0]    BIT_LAST = 4'(DATA_BITS - 1);

  logic [1:0]           r_sync;
  logic [2:0]           r_state;
  logic [OW-1:0]        r_os_cnt;
  logic [3:0]           r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_s0, r_s1;
  logic                 r_ferr, r_perr;
  logic                 r_seen_high;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid, r_frame_err, r_parity_err, r_overrun;

  logic w_tick, w_rxd_s, w_vote, w_vote_tk, w_bit_end, w_done, w_hs;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .n_rst   (n_rst),
    .os_tick (w_tick)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_sync <= 2'b11;
    else        r_sync <= {r_sync[0], rxd};
  end
  assign w_rxd_s = r_sync[1];

  // Third sample is live on the vote tick; the first two were captured on the preceding ticks.
  assign w_vote    = (r_s0 & r_s1) | (r_s0 & w_rxd_s) | (r_s1 & w_rxd_s);
  assign w_vote_tk = w_tick && (r_state != ST_IDLE) && (r_os_cnt == OS_S2);
  assign w_bit_end = w_tick && (r_os_cnt == OS_END);
  // Frame ends mid-way through the final stop bit so a back-to-back start edge is not missed.
  assign w_done    = w_vote_tk && (r_state == ST_STOP) && ((STOP_BITS == 1) || (r_bit_cnt == 4'd1));
  assign w_hs      = r_valid && rx_ready;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= ST_IDLE;
      r_os_cnt    <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_s0        <= 1'b0;
      r_s1        <= 1'b0;
      r_ferr      <= 1'b0;
      r_perr      <= 1'b0;
      r_seen_high <= 1'b0;
    end else begin
      // A new start needs a high line after the previous frame, so a held break yields one frame, not a stream.
      if (w_done)       r_seen_high <= 1'b0;
      else if (w_rxd_s) r_seen_high <= 1'b1;

      if (w_tick) begin
        if (r_state == ST_IDLE) begin
          if (!w_rxd_s && r_seen_high) begin
            r_state  <= ST_START;
            r_os_cnt <= '0;
            r_ferr   <= 1'b0;
            r_perr   <= 1'b0;
          end
        end else begin
          r_os_cnt <= (r_os_cnt == OS_END) ? '0 : r_os_cnt + OW'(1);
          if (r_os_cnt == OS_S0) r_s0 <= w_rxd_s;
          if (r_os_cnt == OS_S1) r_s1 <= w_rxd_s;
          case (r_state)
            ST_START: begin
              if (w_vote_tk && w_vote) begin
                r_state <= ST_IDLE;
              end else if (w_bit_end) begin
                r_state   <= ST_DATA;
                r_bit_cnt <= '0;
              end
            end
            ST_DATA: begin
              if (w_vote_tk) r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
              if (w_bit_end) begin
                if (r_bit_cnt == BIT_LAST) begin
                  r_state   <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                  r_bit_cnt <= '0;
                end else begin
                  r_bit_cnt <= r_bit_cnt + 4'd1;
                end
              end
            end
            ST_PARITY: begin
              // Odd: data^p must be 1; even: must be 0.
              if (w_vote_tk) r_perr <= (^r_shift) ^ w_vote ^ (PARITY == PARITY_ODD);
              if (w_bit_end) r_state <= ST_STOP;
            end
            ST_STOP: begin
              if (w_vote_tk) r_ferr <= r_ferr | ~w_vote;
              if (w_done)         r_state   <= ST_IDLE;
              else if (w_bit_end) r_bit_cnt <= 4'd1;
            end
            default: r_state <= ST_IDLE;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (w_done && (!r_valid || rx_ready)) begin
        r_data       <= r_shift;
        r_frame_err  <= r_ferr | ~w_vote;
        r_parity_err <= r_perr;
        r_valid      <= 1'b1;
      end else if (w_hs) begin
        r_valid      <= 1'b0;
        r_frame_err  <= 1'b0;
        r_parity_err <= 1'b0;
      end
      if (w_hs)                   r_overrun <= 1'b0;
      else if (w_done && r_valid) r_overrun <= 1'b1;
    end
  end

  assign rx_data    = r_data;
  assign rx_valid   = r_valid;
  assign frame_err  = r_frame_err;
  assign parity_err = r_parity_err;
  assign overrun    = r_overrun;
  assign busy       = (r_state != ST_IDLE);

endmodule
